d2l_master_arb: RTL and testbench

D2L_MASTER_ARB -- requirements
Module: d2l_master_arb

---
 rtl/d2l_master_arb.sv | 210 +++++++++++++++++++++
 tb/tb_d2l_master_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d2l_master_arb.sv
// d2l_master_arb
//   Round-robin arbiter and serialiser for a shared two-wire D2L link.
//   NREQ requesters compete for the link. The winner's slave address and
//   data word are latched at arbitration. One frame is then driven:
//   START (1/1), DATA_W/2 bit pairs MSB first, optional PAR, END (0/0).
//   All outputs come straight from flops.
//
// Optional feature:
//   D2L_PARITY_EN  when defined, a PAR cycle follows the last data pair.
//                  It drives InLine1=0 and InLine0 = XOR of the data word.
//
// Ports:
//   sclk               clock; all state changes on posedge
//   rst_n              asynchronous active-low reset
//   req[NREQ]          per-requester level request
//   req_addr[NREQ*AW]  slave address of requester i at [i*AW +: AW]
//   req_data[NREQ*DATA_W] data word of requester i at [i*DATA_W +: DATA_W]
//   gnt[NREQ]          one-cycle pulse in START for the winner
//   done[NREQ]         one-cycle pulse in END for the winner
//   busy               high while a frame is in progress
//   cs_n[NSLV]         active-low slave selects, held START..END
//   InLine1, InLine0   D2L data lines
module d2l_master_arb #(
  parameter int NREQ   = 4,
  parameter int NSLV   = 4,
  parameter int AW     = 2,
  parameter int DATA_W = 8
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [NSLV-1:0]          cs_n,
  output logic                     InLine0,
  output logic                     InLine1
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NPAIR = DATA_W / 2;
  localparam int CW    = $clog2(NPAIR + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, END} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                busy_q, busy_d;
  logic [NSLV-1:0]     cs_n_q, cs_n_d;
  logic                line1_q, line1_d;
  logic                line0_q, line0_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
`ifdef D2L_PARITY_EN
  logic                par_q, par_d;
`endif

  logic                found;
  logic [IW-1:0]       win;
  logic [AW-1:0]       sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Addresses with no matching slave leave every select deasserted.
  function automatic logic [NSLV-1:0] cs_decode(input logic [AW-1:0] a);
    logic [NSLV-1:0] r;
    r = '1;
    for (int s = 0; s < NSLV; s++) begin
      if (a == AW'(s)) r[s] = 1'b0;
    end
    return r;
  endfunction

  // Round-robin scan: start just after the last winner, wrap around.
  // The last winner is therefore the lowest priority.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    sel_addr = req_addr[int'(win)*AW +: AW];
    sel_data = req_data[int'(win)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef D2L_PARITY_EN
    par_d   = par_q;
`endif
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = busy_q;
    cs_n_d  = cs_n_q;
    line1_d = 1'b0;
    line0_d = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cs_n_d = '1;
        if (found) begin
          state_d = START;
          ptr_d   = win;
          shift_d = sel_data;
`ifdef D2L_PARITY_EN
          par_d   = ^sel_data;
`endif
          gnt_d   = NREQ'(1) << win;
          busy_d  = 1'b1;
          cs_n_d  = cs_decode(sel_addr);
          line1_d = 1'b1;
          line0_d = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        line1_d = shift_q[DATA_W-1];
        line0_d = shift_q[DATA_W-2];
        shift_d = shift_q << 2;
      end
      DATA: begin
        // cnt_q is the index of the pair currently on the lines.
        if (cnt_q == CW'(NPAIR - 1)) begin
`ifdef D2L_PARITY_EN
          state_d = PAR;
          line0_d = par_q;
`else
          state_d = END;
          done_d  = NREQ'(1) << ptr_q;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          line1_d = shift_q[DATA_W-1];
          line0_d = shift_q[DATA_W-2];
          shift_d = shift_q << 2;
        end
      end
`ifdef D2L_PARITY_EN
      PAR: begin
        state_d = END;
        done_d  = NREQ'(1) << ptr_q;
      end
`endif
      END: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cs_n_d  = '1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cs_n_d  = '1;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      cs_n_q  <= '1;
      line1_q <= 1'b0;
      line0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      line1_q <= line1_d;
      line0_q <= line0_d;
    end
  end

  // The latched word is only read while a frame runs, so it needs no reset.
  always_ff @(posedge sclk) begin
    shift_q <= shift_d;
`ifdef D2L_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign cs_n    = cs_n_q;
  assign InLine1 = line1_q;
  assign InLine0 = line0_q;

endmodule

// File: tb/tb_d2l_master_arb.sv
module tb_d2l_master_arb;

  localparam int NREQ   = 4;
  localparam int NSLV   = 4;
  localparam int AW     = 3;
  localparam int DATA_W = 8;
  localparam int NPAIR  = DATA_W / 2;
`ifdef D2L_PARITY_EN
  localparam int PEXTRA = 1;
`else
  localparam int PEXTRA = 0;
`endif
  localparam int PERIOD = NPAIR + 3 + PEXTRA;
  localparam int VW     = 2*NREQ + NSLV + 3;
  typedef logic [VW-1:0] vec_t;

  logic                   sclk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   busy;
  logic [NSLV-1:0]        cs_n;
  logic                   InLine0;
  logic                   InLine1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  d2l_master_arb #(.NREQ(NREQ), .NSLV(NSLV), .AW(AW), .DATA_W(DATA_W)) dut (
    .sclk(sclk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .done(done), .busy(busy),
    .cs_n(cs_n), .InLine0(InLine0), .InLine1(InLine1)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                              input logic b, input logic [NSLV-1:0] c,
                              input logic l1, input logic l0);
    return {g, d, b, c, l1, l0};
  endfunction

  // Frame-schedule model: on each grant the whole frame's output sequence is
  // queued from the protocol rules; one entry is consumed per cycle.
  vec_t exp_q[$];
  int   m_ptr = NREQ - 1;
  vec_t idle_v;
  assign idle_v = mk('0, '0, 1'b0, '1, 1'b0, 1'b0);

  always @(posedge sclk or negedge rst_n) begin
    int w;
    int idx;
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] dt;
    logic [NSLV-1:0]   c;
    logic [NREQ-1:0]   g;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = NREQ - 1;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else begin
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        idx = (m_ptr + i) % NREQ;
        if (w < 0 && req[idx]) w = idx;
      end
      if (w >= 0) begin
        a  = req_addr[w*AW +: AW];
        dt = req_data[w*DATA_W +: DATA_W];
        c  = (int'(a) < NSLV) ? ~(NSLV'(1) << a) : '1;
        g  = NREQ'(1) << w;
        exp_q.push_back(mk(g, '0, 1'b1, c, 1'b1, 1'b1));
        for (int k = 0; k < NPAIR; k++)
          exp_q.push_back(mk('0, '0, 1'b1, c, dt[DATA_W-1-2*k], dt[DATA_W-2-2*k]));
`ifdef D2L_PARITY_EN
        exp_q.push_back(mk('0, '0, 1'b1, c, 1'b0, ^dt));
`endif
        exp_q.push_back(mk('0, g, 1'b1, c, 1'b0, 1'b0));
        m_ptr = w;
      end
    end
  end

  always @(negedge sclk) begin
    vec_t e;
    if (started) begin
      e = (exp_q.size() > 0) ? exp_q[0] : idle_v;
      check("cycle", 32'(mk(gnt, done, busy, cs_n, InLine1, InLine0)), 32'(e));
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    @(negedge sclk);
    #1 rst_n = 1'b0;
    req = '0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(output int who, output int at);
    bit seen;
    seen = 1'b0; who = -1; at = cyc;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sclk);
      if (gnt != '0) begin
        seen = 1'b1; at = cyc;
        for (int b = 0; b < NREQ; b++) if (gnt[b]) who = b;
      end
    end
    check("gnt_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int who, at, prev_at, n;
    bit got;
    logic [1:0] lq[$];
    int order[5];
    rst_n = 1'b1; req = '0; req_addr = '0; req_data = '0;
    #2 rst_n = 1'b0;
    started = 1'b1;
    #1 check("reset_state", 32'({gnt, done, busy, cs_n, InLine1, InLine0}),
             32'({4'b0000, 4'b0000, 1'b0, 4'b1111, 2'b00}));
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;

    // Single frame, addr 2, data 0xB4.
    @(negedge sclk);
    set_req(0, 3'd2, 8'hB4);
    @(negedge sclk);
    req = '0;
    lq = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
`ifdef D2L_PARITY_EN
    lq.push_back(2'b00);
`endif
    lq.push_back(2'b00);
    for (int i = 0; i < lq.size(); i++) begin
      if (i > 0) @(negedge sclk);
      check("f1_lines", 32'({InLine1, InLine0}), 32'(lq[i]));
      check("f1_cs", 32'(cs_n), 32'(4'b1011));
      check("f1_gnt", 32'(gnt), (i == 0) ? 32'd1 : 32'd0);
      check("f1_done", 32'(done), (i == lq.size() - 1) ? 32'd1 : 32'd0);
    end
    @(negedge sclk);
    check("f1_after", 32'({busy, cs_n}), 32'({1'b0, 4'b1111}));

    // All requesters held: rotation and fixed frame period.
    do_reset();
    set_req(0, 3'd0, 8'h3C); set_req(1, 3'd0, 8'hA5);
    set_req(2, 3'd0, 8'h0F); set_req(3, 3'd0, 8'hE1);
    prev_at = 0;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(who, at);
      order[f] = who;
      if (f > 0) check("rr_period", 32'(at - prev_at), 32'(PERIOD));
      prev_at = at;
    end
    req = '0;
    check("rr_order", 32'({order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]}),
          32'h01230);
    repeat (10) @(negedge sclk);

    // Held requester yields to a newly raised one.
    do_reset();
    set_req(0, 3'd1, 8'h11);
    wait_gnt(who, at);
    check("hold_g0", 32'(who), 32'd0);
    repeat (2) @(negedge sclk);
    set_req(2, 3'd3, 8'h96);
    wait_gnt(who, at);
    check("hold_g1", 32'(who), 32'd2);
    wait_gnt(who, at);
    check("hold_g2", 32'(who), 32'd0);
    req = '0;
    repeat (10) @(negedge sclk);

    // Address beyond the slave range.
    do_reset();
    set_req(1, 3'd7, 8'h5A);
    wait_gnt(who, at);
    req = '0;
    check("oor_who", 32'(who), 32'd1);
    check("oor_cs", 32'(cs_n), 32'hF);
    n = 0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge sclk);
      if (done != '0) begin got = 1'b1; n = i; end
    end
    check("oor_done_lat", 32'(n), 32'(NPAIR + 1 + PEXTRA));
    check("oor_done_val", 32'(done), 32'h2);
    repeat (4) @(negedge sclk);

    // Reset in the middle of DATA cycle 2.
    do_reset();
    set_req(0, 3'd1, 8'hC3);
    wait_gnt(who, at);
    req = '0;
    repeat (3) @(negedge sclk);
    #1 rst_n = 1'b0;
    #1 check("abort", 32'({gnt, done, busy, cs_n, InLine1, InLine0}),
             32'({4'b0000, 4'b0000, 1'b0, 4'b1111, 2'b00}));
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    set_req(1, 3'd0, 8'h77);
    wait_gnt(who, at);
    req = '0;
    check("abort_regnt", 32'(who), 32'd1);
    repeat (10) @(negedge sclk);

`ifdef D2L_PARITY_EN
    do_reset();
    set_req(0, 3'd2, 8'hB4);
    wait_gnt(who, at);
    req = '0;
    repeat (NPAIR + 1) @(negedge sclk);
    check("par_b4", 32'({InLine1, InLine0}), 32'(2'b00));
    repeat (4) @(negedge sclk);
    set_req(0, 3'd2, 8'hB5);
    wait_gnt(who, at);
    req = '0;
    repeat (NPAIR + 1) @(negedge sclk);
    check("par_b5", 32'({InLine1, InLine0}), 32'(2'b01));
    repeat (4) @(negedge sclk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
